cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
Shares the single common data bus (CDB) between the two execution-result producers, the ALU (RS_EX) and the load/store unit (LS_EX).
Buffers each producer's results in a small per-source FIFO and grants one result per cycle by round-robin.
Drives the registered CDB that the ROB, RS, LSB and the dispatch forwarding logic all snoop.
Flushes all buffered results on a ROB rollback.

Parameters:
FIFO_DEPTH, 4, entries per source FIFO; power of two, at least 2.
ROB_ID_WIDTH, 4, width of a ROB tag.
DATA_WIDTH, 32, result width.

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
rdy  in  1  global ready; low freezes the block
rollback_sign_from_rob  in  1  misprediction flush
valid_sign_from_rs_ex  in  1  ALU result push
rob_id_from_rs_ex  in  ROB_ID_WIDTH  ALU result tag
data_from_rs_ex  in  DATA_WIDTH  ALU result value
ready_to_rs_ex  out  1  ALU FIFO can accept a push
valid_sign_from_ls_ex  in  1  LSU result push
rob_id_from_ls_ex  in  ROB_ID_WIDTH  LSU result tag
data_from_ls_ex  in  DATA_WIDTH  LSU result value
ready_to_ls_ex  out  1  LSU FIFO can accept a push
cdb_valid_sign  out  1  broadcast valid
cdb_rob_id  out  ROB_ID_WIDTH  broadcast tag
cdb_data  out  DATA_WIDTH  broadcast value
cdb_src  out  1  granted source: 0 = ALU, 1 = LSU

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - cdb_valid_sign=0, cdb_rob_id=0, cdb_data=0, cdb_src=0.
  - Both FIFOs empty: head, tail and count = 0.
  - last_grant = LSU, so the ALU wins the first tie.
  - ready_to_* = 1.
- Reset asserted mid-operation discards all queued and in-flight results.
- ready_to_X = (count_X < FIFO_DEPTH), decoded from registered count only; no combinational path from the pop.
- A push is accepted only when valid && ready && rdy && !rollback.
  - A push offered while ready=0 is the producer's error; it is dropped.
- Each rising edge with rdy=1 and no rollback:
  - Candidate X exists if count_X > 0 (head entry).
  - Grant: if both candidates exist, pick the source != last_grant; otherwise pick the sole candidate.
  - On a grant: cdb_* <= granted entry, cdb_valid_sign <= 1, pop that FIFO, last_grant <= granted source.
  - No grant: cdb_valid_sign <= 0; cdb_rob_id, cdb_data and cdb_src hold.
  - Push and pop on the same FIFO in one cycle: count unchanged, entry order preserved (FIFO per source).
  - Pointers are log2(FIFO_DEPTH) bits and wrap naturally; count is log2(FIFO_DEPTH)+1 bits.
- Rollback (rdy=1): both FIFOs cleared, cdb_valid_sign <= 0, same-cycle pushes dropped, last_grant unchanged.
  - Rollback has priority over push and grant.
- rdy=0: all state and outputs hold; pushes and pops are ignored. Producers are frozen by the same rdy.
- Latency from push to CDB: 2 cycles minimum, or 1 cycle with bypass (see below).
- Throughput: one broadcast per cycle. There is no starvation: round-robin guarantees a waiting source a grant within 2 cycles.

Optional Feature:
CDB_BYPASS_EN
- Defined:
  - When count_X == 0 and an accepted push from X arrives, that incoming entry becomes X's candidate in the same cycle.
  - If granted, it goes straight to cdb_* and is not written into the FIFO (latency 1).
  - If it loses arbitration, it is written into the FIFO normally.
- Undefined: candidates are FIFO heads only; minimum latency is 2.

Decomposition:
- Shared defines file: ROB_ID_TYPE and DATA_TYPE widths, INVALID_ROB, TRUE/FALSE, and source encodings SRC_ALU=0, SRC_LSU=1.
- One sub-module, result_fifo (push/pop/flush, count, head outputs, full), instantiated twice.
- Arbiter and output register stay in cdb_arbiter.

Test Plan:
- Single ALU push rob_id=5, data=0x00001234 → cdb_valid_sign=1, cdb_rob_id=5, cdb_data=0x1234, cdb_src=0, 1 cycle later with bypass or 2 without; valid=0 the following cycle.
- Both sources push every cycle for 10 cycles with ALU tags 0..9 and LSU tags 8..15,0,1:
  - CDB alternates ALU, LSU, ALU..., starting with ALU.
  - Each source's tags appear in push order.
  - ready_to_* drops to 0 when its count reaches 4.
  - No result is lost or duplicated.
- Queue 3 ALU and 2 LSU results, then pulse rollback_sign_from_rob → next cycle cdb_valid_sign=0, ready both 1; a fresh push rob_id=2 is broadcast normally.
- Entries queued, rdy=0 for 3 cycles with valid pushes offered → cdb_* frozen, counts unchanged, pushes lost; draining resumes in order when rdy=1.
- rst asserted asynchronously between edges with 4 entries queued → outputs go to 0 before the next edge; ready_to_*=1; first post-reset tie grants the ALU.
- Wrap-around: 12 sequential ALU pushes at one per cycle, LSU idle → all 12 broadcast in order, and count never exceeds 1 with bypass or 2 without.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared widths, constants and source encodings for the CDB arbiter.
package cdb_arbiter_pkg;
    localparam int ROB_ID_TYPE_W = 4;
    localparam int DATA_TYPE_W   = 32;

    localparam logic [ROB_ID_TYPE_W-1:0] INVALID_ROB = '0;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LSU = 1'b1
    } src_e;
endpackage

// File: rtl/cdb_arbiter_result_fifo.sv
// Per-source result FIFO: power-of-two depth, naturally wrapping pointers, flush clears.
module result_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 36
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
    logic [PW-1:0]           head_ptr_q, head_ptr_d;
    logic [PW-1:0]           tail_ptr_q, tail_ptr_d;
    logic [CW-1:0]           count_q, count_d;

    always_comb begin
        mem_d      = mem_q;
        head_ptr_d = head_ptr_q;
        tail_ptr_d = tail_ptr_q;
        count_d    = count_q;
        if (flush) begin
            head_ptr_d = '0;
            tail_ptr_d = '0;
            count_d    = '0;
        end else begin
            if (push) begin
                mem_d[tail_ptr_q] = din;
                tail_ptr_d        = tail_ptr_q + PW'(1);
            end
            if (pop) head_ptr_d = head_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q      <= '0;
            head_ptr_q <= '0;
            tail_ptr_q <= '0;
            count_q    <= '0;
        end else begin
            mem_q      <= mem_d;
            head_ptr_q <= head_ptr_d;
            tail_ptr_q <= tail_ptr_d;
            count_q    <= count_d;
        end
    end

    assign head  = mem_q[head_ptr_q];
    assign count = count_q;
    assign full  = (count_q == CW'(DEPTH));
endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing the registered CDB between ALU and LSU result FIFOs.
// Define CDB_BYPASS_EN to let a push into an empty FIFO compete for the CDB in the same cycle.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int ROB_ID_WIDTH = ROB_ID_TYPE_W,
    parameter int DATA_WIDTH   = DATA_TYPE_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,
    input  logic                    rollback_sign_from_rob,
    input  logic                    valid_sign_from_rs_ex,
    input  logic [ROB_ID_WIDTH-1:0] rob_id_from_rs_ex,
    input  logic [DATA_WIDTH-1:0]   data_from_rs_ex,
    output logic                    ready_to_rs_ex,
    input  logic                    valid_sign_from_ls_ex,
    input  logic [ROB_ID_WIDTH-1:0] rob_id_from_ls_ex,
    input  logic [DATA_WIDTH-1:0]   data_from_ls_ex,
    output logic                    ready_to_ls_ex,
    output logic                    cdb_valid_sign,
    output logic [ROB_ID_WIDTH-1:0] cdb_rob_id,
    output logic [DATA_WIDTH-1:0]   cdb_data,
    output logic                    cdb_src
);
    localparam int EW = ROB_ID_WIDTH + DATA_WIDTH;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [1:0][EW-1:0] fifo_in, head, cand_e;
    logic [1:0][CW-1:0] cnt;
    logic [1:0]         valid_in, full, acc, byp, cand, push, pop;
    logic               flush, gnt_vld, gnt_src;

    logic                    cdb_valid_q, cdb_valid_d;
    logic [ROB_ID_WIDTH-1:0] cdb_rob_id_q, cdb_rob_id_d;
    logic [DATA_WIDTH-1:0]   cdb_data_q, cdb_data_d;
    logic                    cdb_src_q, cdb_src_d;
    logic                    last_grant_q, last_grant_d;

    assign valid_in = {valid_sign_from_ls_ex, valid_sign_from_rs_ex};
    assign fifo_in  = {{rob_id_from_ls_ex, data_from_ls_ex},
                       {rob_id_from_rs_ex, data_from_rs_ex}};
    assign flush    = rdy && rollback_sign_from_rob;

    for (genvar s = 0; s < 2; s++) begin : g_src
        // Ready comes from the registered count, so a same-cycle pop never frees a slot.
        assign acc[s] = valid_in[s] && !full[s] && rdy && !rollback_sign_from_rob;
`ifdef CDB_BYPASS_EN
        assign byp[s] = acc[s] && (cnt[s] == '0);
`else
        assign byp[s] = FALSE;
`endif
        assign cand[s]   = (cnt[s] != '0) || byp[s];
        assign cand_e[s] = byp[s] ? fifo_in[s] : head[s];
        assign pop[s]    = gnt_vld && (gnt_src == 1'(s)) && (cnt[s] != '0);
        assign push[s]   = acc[s] && !(byp[s] && gnt_vld && (gnt_src == 1'(s)));

        result_fifo #(
            .DEPTH (FIFO_DEPTH),
            .W     (EW)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .flush (flush),
            .push  (push[s]),
            .pop   (pop[s]),
            .din   (fifo_in[s]),
            .head  (head[s]),
            .count (cnt[s]),
            .full  (full[s])
        );
    end

    always_comb begin
        gnt_vld = FALSE;
        gnt_src = SRC_ALU;
        if (rdy && !rollback_sign_from_rob) begin
            if (cand[SRC_ALU] && cand[SRC_LSU]) begin
                gnt_vld = TRUE;
                gnt_src = !last_grant_q;
            end else if (cand[SRC_ALU]) begin
                gnt_vld = TRUE;
                gnt_src = SRC_ALU;
            end else if (cand[SRC_LSU]) begin
                gnt_vld = TRUE;
                gnt_src = SRC_LSU;
            end
        end
    end

    always_comb begin
        cdb_valid_d  = cdb_valid_q;
        cdb_rob_id_d = cdb_rob_id_q;
        cdb_data_d   = cdb_data_q;
        cdb_src_d    = cdb_src_q;
        last_grant_d = last_grant_q;
        if (gnt_vld) begin
            cdb_valid_d                = TRUE;
            cdb_src_d                  = gnt_src;
            last_grant_d               = gnt_src;
            {cdb_rob_id_d, cdb_data_d} = cand_e[gnt_src];
        end else if (rdy) begin
            cdb_valid_d = FALSE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cdb_valid_q  <= FALSE;
            cdb_rob_id_q <= ROB_ID_WIDTH'(INVALID_ROB);
            cdb_data_q   <= '0;
            cdb_src_q    <= SRC_ALU;
            last_grant_q <= SRC_LSU;
        end else begin
            cdb_valid_q  <= cdb_valid_d;
            cdb_rob_id_q <= cdb_rob_id_d;
            cdb_data_q   <= cdb_data_d;
            cdb_src_q    <= cdb_src_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign ready_to_rs_ex = !full[SRC_ALU];
    assign ready_to_ls_ex = !full[SRC_LSU];
    assign cdb_valid_sign = cdb_valid_q;
    assign cdb_rob_id     = cdb_rob_id_q;
    assign cdb_data       = cdb_data_q;
    assign cdb_src        = cdb_src_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: vector table plus multi-cycle sequences, both bypass builds.
module tb_cdb_arbiter;
`ifdef CDB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, rdy, rb;
    logic        va, vl;
    logic [3:0]  ida, idl;
    logic [31:0] da, dl;
    logic        ra, rl, cv, cs;
    logic [3:0]  cid;
    logic [31:0] cdat;

    int checks   = 0;
    int failures = 0;

    cdb_arbiter #(.FIFO_DEPTH(4), .ROB_ID_WIDTH(4), .DATA_WIDTH(32)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .rdy                    (rdy),
        .rollback_sign_from_rob (rb),
        .valid_sign_from_rs_ex  (va),
        .rob_id_from_rs_ex      (ida),
        .data_from_rs_ex        (da),
        .ready_to_rs_ex         (ra),
        .valid_sign_from_ls_ex  (vl),
        .rob_id_from_ls_ex      (idl),
        .data_from_ls_ex        (dl),
        .ready_to_ls_ex         (rl),
        .cdb_valid_sign         (cv),
        .cdb_rob_id             (cid),
        .cdb_data               (cdat),
        .cdb_src                (cs)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rdy, rb, va;
        logic [3:0]  ida;
        logic [31:0] da;
        logic        vl;
        logic [3:0]  idl;
        logic [31:0] dl;
        logic        ev;
        logic [3:0]  eid;
        logic [31:0] ed;
        logic        es;
    } vec_t;

    vec_t vt[11];

    function automatic vec_t mk(input logic r, b, a, input logic [3:0] ia, input logic [31:0] dA,
                                input logic l, input logic [3:0] il, input logic [31:0] dL,
                                input logic ev, input logic [3:0] eid, input logic [31:0] ed,
                                input logic es);
        vec_t v;
        v.rdy = r; v.rb = b; v.va = a; v.ida = ia; v.da = dA;
        v.vl = l; v.idl = il; v.dl = dL;
        v.ev = ev; v.eid = eid; v.ed = ed; v.es = es;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        rdy = 1'b1; rb = 1'b0; va = 1'b0; vl = 1'b0;
        ida = '0; da = '0; idl = '0; dl = '0;
    endtask

    task automatic push2(input logic a, input logic [3:0] ia, input logic [31:0] dA,
                         input logic l, input logic [3:0] il, input logic [31:0] dL);
        va = a; ida = ia; da = dA; vl = l; idl = il; dl = dL;
    endtask

    task automatic do_reset;
        idle();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic chk_out(input string nm, input logic ev, input logic [3:0] eid,
                           input logic [31:0] ed, input logic es);
        chk({nm, "_valid"}, cv, ev);
        chk({nm, "_id"}, cid, eid);
        chk({nm, "_data"}, cdat, ed);
        chk({nm, "_src"}, cs, es);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1);
    end

    initial begin
        logic [35:0] qa[$], ql[$];
        logic [35:0] e;
        int na, nl, nbc, maxocc;
        logic acc_a, acc_l, exp_src, lowa, lowl, got;

        vt[0]  = mk(1,0,1,4'd5,32'h1234,0,0,0, BYP, BYP ? 4'd5 : 4'd0, BYP ? 32'h1234 : 32'h0, 0);
        vt[1]  = mk(1,0,0,0,0,0,0,0, !BYP, 4'd5, 32'h1234, 0);
        vt[2]  = mk(1,0,0,0,0,0,0,0, 0, 4'd5, 32'h1234, 0);
        vt[3]  = mk(1,0,1,4'd1,32'h11,1,4'd2,32'h22, BYP, BYP ? 4'd2 : 4'd5,
                    BYP ? 32'h22 : 32'h1234, BYP);
        vt[4]  = mk(1,0,0,0,0,0,0,0, 1, BYP ? 4'd1 : 4'd2, BYP ? 32'h11 : 32'h22, !BYP);
        vt[5]  = mk(1,0,0,0,0,0,0,0, !BYP, 4'd1, 32'h11, 0);
        vt[6]  = mk(1,0,0,0,0,0,0,0, 0, 4'd1, 32'h11, 0);
        vt[7]  = mk(1,1,1,4'd3,32'h33,0,0,0, 0, 4'd1, 32'h11, 0);
        vt[8]  = mk(1,0,0,0,0,0,0,0, 0, 4'd1, 32'h11, 0);
        vt[9]  = mk(0,0,1,4'd4,32'h44,0,0,0, 0, 4'd1, 32'h11, 0);
        vt[10] = mk(1,0,0,0,0,0,0,0, 0, 4'd1, 32'h11, 0);

        // Reset state is visible while reset is still asserted.
        idle();
        rst = 1'b1;
        #1;
        chk_out("reset", 0, 0, 0, 0);
        chk("reset_ready_alu", ra, 1);
        chk("reset_ready_lsu", rl, 1);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            rdy = vt[i].rdy; rb = vt[i].rb;
            push2(vt[i].va, vt[i].ida, vt[i].da, vt[i].vl, vt[i].idl, vt[i].dl);
            tick();
            chk_out($sformatf("vec%0d", i), vt[i].ev, vt[i].eid, vt[i].ed, vt[i].es);
            chk($sformatf("vec%0d_ready_alu", i), ra, 1);
            chk($sformatf("vec%0d_ready_lsu", i), rl, 1);
        end

        // Rollback with entries queued in both FIFOs.
        idle();
        push2(1, 4'd10, 32'hA, 1, 4'd11, 32'hB); tick();
        push2(1, 4'd12, 32'hC, 1, 4'd13, 32'hD); tick();
        push2(1, 4'd14, 32'hE, 0, 0, 0);          tick();
        idle(); rb = 1'b1;                        tick();
        chk("rb_valid", cv, 0);
        chk("rb_ready_alu", ra, 1);
        chk("rb_ready_lsu", rl, 1);
        idle(); tick();
        chk("rb_flushed_valid", cv, 0);
        push2(1, 4'd2, 32'h2222, 0, 0, 0); tick();
        idle();
        got = 1'b0;
        for (int i = 0; i < 4 && !got; i++) begin
            if (cv) got = 1'b1;
            else tick();
        end
        chk("rb_fresh_seen", got, 1);
        chk("rb_fresh_id", cid, 4'd2);
        chk("rb_fresh_data", cdat, 32'h2222);

        // Freeze with rdy=0 while pushes are offered.
        do_reset();
        push2(1, 4'd6, 32'h66, 1, 4'd9, 32'h99); tick();
        chk_out("frz_e1", BYP, BYP ? 4'd6 : 4'd0, BYP ? 32'h66 : 32'h0, 0);
        for (int i = 0; i < 3; i++) begin
            rdy = 1'b0;
            push2(1, 4'd12, 32'hC, 1, 4'd13, 32'hD);
            tick();
            chk_out($sformatf("frz_hold%0d", i), BYP, BYP ? 4'd6 : 4'd0, BYP ? 32'h66 : 32'h0, 0);
            chk($sformatf("frz_hold%0d_ready", i), {ra, rl}, 2'b11);
        end
        idle(); tick();
        chk_out("frz_r1", 1, BYP ? 4'd9 : 4'd6, BYP ? 32'h99 : 32'h66, BYP);
        tick();
        chk_out("frz_r2", !BYP, 4'd9, 32'h99, 1);
        tick();
        chk_out("frz_r3", 0, 4'd9, 32'h99, 1);

        // Asynchronous reset between edges with results queued.
        do_reset();
        push2(1, 4'd1, 32'h1, 1, 4'd2, 32'h2); tick();
        push2(1, 4'd3, 32'h3, 1, 4'd4, 32'h4); tick();
        push2(1, 4'd5, 32'h5, 1, 4'd6, 32'h6); tick();
        idle();
        chk("arst_pre_valid", cv, 1);
        #2 rst = 1'b1;
        #1;
        chk_out("arst", 0, 0, 0, 0);
        chk("arst_ready", {ra, rl}, 2'b11);
        @(negedge clk);
        rst = 1'b0;
        push2(1, 4'd7, 32'h77, 1, 4'd8, 32'h88); tick();
        idle();
        got = 1'b0;
        for (int i = 0; i < 4 && !got; i++) begin
            if (cv) got = 1'b1;
            else tick();
        end
        chk("arst_tie_seen", got, 1);
        chk("arst_tie_src", cs, 0);
        chk("arst_tie_id", cid, 4'd7);
        tick();
        chk_out("arst_second", 1, 4'd8, 32'h88, 1);

        // Both sources streaming; producers hold an offer while ready is low.
        do_reset();
        na = 0; nl = 0; nbc = 0; exp_src = 1'b0; lowa = 1'b0; lowl = 1'b0;
        for (int c = 0; c < 80 && nbc < 20; c++) begin
            push2(na < 10, 4'(na), 32'hA000 + na, nl < 10, 4'(8 + nl), 32'hB000 + nl);
            acc_a = va && ra;
            acc_l = vl && rl;
            if (!ra) lowa = 1'b1;
            if (!rl) lowl = 1'b1;
            tick();
            if (acc_a) begin qa.push_back({ida, da}); na++; end
            if (acc_l) begin ql.push_back({idl, dl}); nl++; end
            if (cv) begin
                chk($sformatf("rr_src%0d", nbc), cs, exp_src);
                if (cs == 1'b0 && qa.size() > 0) begin
                    e = qa.pop_front();
                    chk($sformatf("rr_alu%0d", nbc), {cid, cdat}, e);
                end else if (cs == 1'b1 && ql.size() > 0) begin
                    e = ql.pop_front();
                    chk($sformatf("rr_lsu%0d", nbc), {cid, cdat}, e);
                end else begin
                    chk($sformatf("rr_unexpected%0d", nbc), {cs, cid, cdat}, 0);
                end
                exp_src = !exp_src;
                nbc++;
            end
        end
        idle();
        chk("rr_broadcasts", nbc, 20);
        chk("rr_alu_left", qa.size(), 0);
        chk("rr_lsu_left", ql.size(), 0);
        chk("rr_alu_ready_dropped", lowa, 1);
        chk("rr_lsu_ready_dropped", lowl, 1);
        tick();
        chk("rr_drained_valid", cv, 0);

        // Wrap-around: 12 back-to-back ALU pushes.
        do_reset();
        qa.delete();
        na = 0; nbc = 0; maxocc = 0; lowa = 1'b0;
        for (int c = 0; c < 40 && nbc < 12; c++) begin
            push2(na < 12, 4'(na), 32'hC00 + na, 0, 0, 0);
            acc_a = va && ra;
            if (!ra) lowa = 1'b1;
            tick();
            if (acc_a) begin qa.push_back({ida, da}); na++; end
            if (cv) begin
                chk($sformatf("wrap_src%0d", nbc), cs, 0);
                if (qa.size() > 0) begin
                    e = qa.pop_front();
                    chk($sformatf("wrap_item%0d", nbc), {cid, cdat}, e);
                end else begin
                    chk($sformatf("wrap_extra%0d", nbc), {cid, cdat}, 0);
                end
                nbc++;
            end
            if (qa.size() > maxocc) maxocc = qa.size();
        end
        idle();
        chk("wrap_broadcasts", nbc, 12);
        chk("wrap_ready_low", lowa, 0);
        chk("wrap_occupancy_ok", maxocc <= (BYP ? 1 : 2), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
